// File: rtl/fpu_ftoi_seq.sv
// Sequential IEEE-754 single to signed int32 converter using a multi-cycle right shifter.
// Build option: define FPU_FTOI_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module fpu_ftoi_seq #(
  parameter int C_OP         = 32,
  parameter int C_SHIFT_STEP = 4
) (
  input  logic            Clk_CI,
  input  logic            Rst_RI,
  input  logic [C_OP-1:0] Operand_a_DI,
  input  logic            Valid_SI,
  output logic            Ready_SO,
  output logic [C_OP-1:0] Result_DO,
  output logic            Invalid_SO,
  output logic            Inexact_SO,
  output logic            Valid_SO,
  input  logic            Ready_SI
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] C_STEP = 6'(C_SHIFT_STEP);

  state_t      state_r, state_s;
  logic [31:0] mant_r, mant_s;
  logic [5:0]  rem_r, rem_s;
  logic        guard_r, guard_s;
  logic        sticky_r, sticky_s;
  logic        sign_r, sign_s;
  logic [31:0] result_r, result_s;
  logic        invalid_r, invalid_s;
  logic        inexact_r, inexact_s;

  logic        sign_in_s;
  logic [7:0]  exp_in_s;
  logic [22:0] frac_in_s;
  logic [5:0]  amt_s;
  logic [4:0]  gidx_s;
  logic [31:0] lost_mask_s;
  logic [31:0] shifted_s;
  logic [5:0]  rem_next_s;
  logic        guard_in_s;
  logic        sticky_in_s;
  logic        round_inc_s;
  logic [32:0] mag_s;
  logic        ovf_s;

  assign sign_in_s = Operand_a_DI[31];
  assign exp_in_s  = Operand_a_DI[30:23];
  assign frac_in_s = Operand_a_DI[22:0];

  // One shift step: amt bits leave the bottom; the top one becomes guard, the rest fold into sticky.
  assign amt_s       = (rem_r < C_STEP) ? rem_r : C_STEP;
  assign gidx_s      = 5'(amt_s - 6'd1);
  assign lost_mask_s = (32'd1 << gidx_s) - 32'd1;
  assign shifted_s   = mant_r >> amt_s;
  assign rem_next_s  = rem_r - amt_s;
  assign guard_in_s  = mant_r[gidx_s];
  assign sticky_in_s = sticky_r | guard_r | (|(mant_r & lost_mask_s));

`ifdef FPU_FTOI_RNE_EN
  assign round_inc_s = guard_in_s & (sticky_in_s | shifted_s[0]);
`else
  assign round_inc_s = 1'b0;
`endif

  assign mag_s = {1'b0, shifted_s} + {32'd0, round_inc_s};
  assign ovf_s = sign_r ? (mag_s > 33'h080000000) : (mag_s > 33'h07FFFFFFF);

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_s   = state_r;
    mant_s    = mant_r;
    rem_s     = rem_r;
    guard_s   = guard_r;
    sticky_s  = sticky_r;
    sign_s    = sign_r;
    result_s  = result_r;
    invalid_s = invalid_r;
    inexact_s = inexact_r;
    case (state_r)
      IDLE: begin
        if (Valid_SI) begin
          sign_s   = sign_in_s;
          guard_s  = 1'b0;
          sticky_s = 1'b0;
          mant_s   = 32'd0;
          rem_s    = 6'd0;
          if ((exp_in_s == 8'hFF) && (frac_in_s != 23'd0)) begin
            result_s  = 32'h7FFF_FFFF;
            invalid_s = 1'b1;
            inexact_s = 1'b0;
            state_s   = DONE;
          end else if (exp_in_s >= 8'd158) begin
            // -2^31 itself is representable and is the only E>=31 value without a flag.
            if (sign_in_s) begin
              result_s  = 32'h8000_0000;
              invalid_s = (exp_in_s != 8'd158) || (frac_in_s != 23'd0);
            end else begin
              result_s  = 32'h7FFF_FFFF;
              invalid_s = 1'b1;
            end
            inexact_s = 1'b0;
            state_s   = DONE;
          end else if (exp_in_s <= 8'd125) begin
            result_s  = 32'd0;
            invalid_s = 1'b0;
            inexact_s = (exp_in_s != 8'd0) || (frac_in_s != 23'd0);
            state_s   = DONE;
          end else begin
            mant_s  = {1'b1, frac_in_s, 8'h00};
            rem_s   = 6'(8'd158 - exp_in_s);
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        mant_s   = shifted_s;
        rem_s    = rem_next_s;
        guard_s  = guard_in_s;
        sticky_s = sticky_in_s;
        if (rem_next_s == 6'd0) begin
          if (ovf_s) begin
            result_s  = sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
            invalid_s = 1'b1;
            inexact_s = 1'b0;
          end else begin
            result_s  = sign_r ? (32'd0 - mag_s[31:0]) : mag_s[31:0];
            invalid_s = 1'b0;
            inexact_s = guard_in_s | sticky_in_s;
          end
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (Ready_SI) begin
          result_s  = 32'd0;
          invalid_s = 1'b0;
          inexact_s = 1'b0;
          state_s   = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_r   <= IDLE;
      mant_r    <= 32'd0;
      rem_r     <= 6'd0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      sign_r    <= 1'b0;
      result_r  <= 32'd0;
      invalid_r <= 1'b0;
      inexact_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      mant_r    <= mant_s;
      rem_r     <= rem_s;
      guard_r   <= guard_s;
      sticky_r  <= sticky_s;
      sign_r    <= sign_s;
      result_r  <= result_s;
      invalid_r <= invalid_s;
      inexact_r <= inexact_s;
    end
  end

  assign Ready_SO   = (state_r == IDLE);
  assign Valid_SO   = (state_r == DONE);
  assign Result_DO  = result_r;
  assign Invalid_SO = invalid_r;
  assign Inexact_SO = inexact_r;

endmodule

// File: tb/tb_fpu_ftoi_seq.sv
// Directed bench for fpu_ftoi_seq with C_SHIFT_STEP=4; expectations follow the build's rounding mode.
module tb_fpu_ftoi_seq;

  logic        clk;
  logic        rst;
  logic [31:0] op_a;
  logic        vin;
  logic        rdy_out;
  logic [31:0] res;
  logic        inv;
  logic        inx;
  logic        vout;
  logic        rdy_in;

  int errors = 0;
  int checks = 0;

  fpu_ftoi_seq #(.C_OP(32), .C_SHIFT_STEP(4)) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .Operand_a_DI (op_a),
    .Valid_SI     (vin),
    .Ready_SO     (rdy_out),
    .Result_DO    (res),
    .Invalid_SO   (inv),
    .Inexact_SO   (inx),
    .Valid_SO     (vout),
    .Ready_SI     (rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand, optionally poke Valid_SI while busy, then check result, flags, latency and release.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] exp_res,
                     input logic exp_inv, input logic exp_inx, input int exp_lat, input logic junk);
    int lat;
    chk({tag, ".ready"}, {31'd0, rdy_out}, 32'd1);
    op_a = a;
    vin  = 1'b1;
    tick();
    vin = 1'b0;
    lat = 1;
    if (junk) begin
      op_a = 32'h7FC0_0000;
      vin  = 1'b1;
    end
    while (!vout && lat < 40) begin
      if (!vout) chk({tag, ".res_idle"}, res, 32'd0);
      tick();
      lat++;
    end
    vin = 1'b0;
    chk({tag, ".valid"}, {31'd0, vout}, 32'd1);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, res, exp_res);
    chk({tag, ".inv"}, {31'd0, inv}, {31'd0, exp_inv});
    chk({tag, ".inx"}, {31'd0, inx}, {31'd0, exp_inx});
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk({tag, ".back_idle"}, {30'd0, rdy_out, vout}, 32'd2);
    chk({tag, ".cleared"}, {res[31:2], inv, inx}, 32'd0);
  endtask

  initial begin
    int   hold_bad;
    logic stale;
    rst    = 1'b1;
    op_a   = 32'd0;
    vin    = 1'b0;
    rdy_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.ready_valid", {30'd0, rdy_out, vout}, 32'd2);
    chk("reset.outputs", {res[31:2], inv, inx}, 32'd0);
    chk("reset.res", res, 32'd0);

    run("neg123", 32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 8, 1'b1);
`ifdef FPU_FTOI_RNE_EN
    run("one_half_x3", 32'h3FC0_0000, 32'd2, 1'b0, 1'b1, 9, 1'b0);
    run("neg2p75", 32'hC030_0000, 32'hFFFF_FFFD, 1'b0, 1'b1, 9, 1'b0);
`else
    run("one_half_x3", 32'h3FC0_0000, 32'd1, 1'b0, 1'b1, 9, 1'b0);
    run("neg2p75", 32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 9, 1'b0);
`endif
    run("two_p5", 32'h4020_0000, 32'd2, 1'b0, 1'b1, 9, 1'b0);
    run("half", 32'h3F00_0000, 32'd0, 1'b0, 1'b1, 9, 1'b0);
    run("pos2p31", 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 1'b0);
    run("neg2p31", 32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b0);
    run("nan", 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 1'b0);
    run("neg_inf", 32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 1'b0);
    run("max_shift", 32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 2, 1'b0);
    run("denorm", 32'h0000_0001, 32'd0, 1'b0, 1'b1, 1, 1'b0);
    run("zero", 32'h0000_0000, 32'd0, 1'b0, 1'b0, 1, 1'b0);
    run("quarter", 32'h3E80_0000, 32'd0, 1'b0, 1'b1, 1, 1'b0);

    // Back-pressure: result for 1.0 must hold while Ready_SI stays low.
    op_a = 32'h3F80_0000;
    vin  = 1'b1;
    tick();
    vin = 1'b0;
    for (int i = 0; i < 40 && !vout; i++) tick();
    chk("hold.valid", {31'd0, vout}, 32'd1);
    hold_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res !== 32'd1 || vout !== 1'b1 || rdy_out !== 1'b0) hold_bad++;
    end
    chk("hold.stable", hold_bad, 0);
    chk("hold.res", res, 32'd1);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk("hold.release", {30'd0, rdy_out, vout}, 32'd2);

    // Reset during the second SHIFT cycle of 1.0 discards the operation.
    op_a = 32'h3F80_0000;
    vin  = 1'b1;
    tick();
    vin = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.ready_valid", {30'd0, rdy_out, vout}, 32'd2);
    chk("rst_mid.res", res, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vout !== 1'b0 || res !== 32'd0) stale = 1'b1;
    end
    chk("rst_mid.no_stale", {31'd0, stale}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_ftoi_seq.md
FPU_FTOI_SEQ -- requirements
Module: fpu_ftoi_seq

Interface
REQ-001 SHALL have parameter C_OP, default 32, meaning operand and result width in bits; only 32 (IEEE-754 single to signed int32) is supported.
REQ-002 SHALL have parameter C_SHIFT_STEP, default 4, meaning bits shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.
REQ-003 SHALL have port Clk_CI, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_RI, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port Operand_a_DI, input, C_OP bits: IEEE single-precision operand.
REQ-006 SHALL have port Valid_SI, input, 1 bit: operand valid.
REQ-007 SHALL have port Ready_SO, output, 1 bit: block can accept an operand.
REQ-008 SHALL have port Result_DO, output, C_OP bits: two's-complement integer result.
REQ-009 SHALL have port Invalid_SO, output, 1 bit: invalid-operation flag (NaN, Inf, overflow).
REQ-010 SHALL have port Inexact_SO, output, 1 bit: inexact flag.
REQ-011 SHALL have port Valid_SO, output, 1 bit: result and flags valid.
REQ-012 SHALL have port Ready_SI, input, 1 bit: consumer accepts the result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE; Ready_SO=1 only in IDLE; Valid_SO=1 only in DONE.
REQ-014 SHALL accept an operand on a clock edge where Valid_SI=1 and Ready_SO=1; Valid_SI in other states is ignored.
REQ-015 SHALL decode E = exponent field - 127 and, on acceptance, classify the operand, with special cases going IDLE->DONE.
REQ-016 SHALL, for a NaN operand, produce 0x7FFFFFFF with Invalid=1 and Inexact=0.
REQ-017 SHALL, for +Inf or E>=31 with sign 0, produce 0x7FFFFFFF with Invalid=1.
REQ-018 SHALL, for -Inf or E>=31 with sign 1, produce 0x80000000 with Invalid=1, except exactly -2^31 (0xCF000000), which produces 0x80000000 with no flags.
REQ-019 SHALL, for zero, produce 0 with no flags; for a denormal or E<=-2, produce 0 with Inexact=1.
REQ-020 SHALL, for -1<=E<=30, take the shift path:
- load the 32-bit register with {1, fraction, 8'b0};
- set remaining = 31-E (range 1..32);
- go to SHIFT.
REQ-021 SHALL, in each SHIFT cycle, right-shift by min(C_SHIFT_STEP, remaining) and decrement remaining by the same amount.
REQ-022 SHALL track the guard bit (last bit shifted out) and the sticky bit (OR of all earlier shifted-out bits).
REQ-023 SHALL, in the SHIFT cycle where remaining reaches 0, round, apply the sign (negate if sign=1), register the result and flags, and enter DONE.
REQ-024 SHALL set Inexact=1 on the shift path iff guard|sticky.
REQ-025 SHALL, if the rounded magnitude exceeds 2^31-1 (positive) or 2^31 (negative), saturate per REQ-017/018 with Invalid=1.
REQ-026 SHALL have a latency from the acceptance edge to Valid_SO high of 1 cycle for the special path and 1+ceil((31-E)/C_SHIFT_STEP) cycles for the shift path.
REQ-027 SHALL hold Result_DO, Invalid_SO and Inexact_SO stable in DONE until an edge with Ready_SI=1, then return to IDLE.
REQ-028 SHALL not accept a new operand in the cycle its result is accepted; earliest re-acceptance is the following cycle.
REQ-029 SHALL drive Result_DO, Invalid_SO and Inexact_SO to 0 while not in DONE.

Reset
REQ-030 SHALL, on an edge with Rst_RI=1, enter IDLE from any state, including mid-SHIFT, discarding the operation in flight.
REQ-031 SHALL clear all registers to 0 on reset, giving Ready_SO=1, Valid_SO=0 and all other outputs 0 in the following cycle.

Configuration
REQ-032 SHALL, when macro FPU_FTOI_RNE_EN is defined, round to nearest-even: increment the magnitude iff guard & (sticky | lsb).
REQ-033 SHALL, when FPU_FTOI_RNE_EN is undefined, round toward zero (truncate, no increment), with flags still per REQ-024/025; the port list is identical in both builds.

Verification
REQ-034 SHALL cover: 0xC2F60000 (-123.0), C_SHIFT_STEP=4 -> Result 0xFFFFFF85, no flags, Valid_SO 8 cycles after acceptance.
REQ-035 SHALL cover: 0x3FC00000 (1.5) -> RNE build Result 2, RTZ build Result 1, Inexact=1 in both; 0x3F000000 (0.5) -> Result 0, Inexact=1 in both builds.
REQ-036 SHALL cover: 0x4F000000 -> 0x7FFFFFFF with Invalid=1, latency 1; 0xCF000000 -> 0x80000000 with no flags; 0x7FC00000 -> 0x7FFFFFFF with Invalid=1.
REQ-037 SHALL cover: 0x4EFFFFFF (2147483520.0) -> 0x7FFFFF80, no flags; 0x00000001 (denormal) -> 0 with Inexact=1.
REQ-038 SHALL cover: result for 1.0 held with Ready_SI=0 for 3 cycles -> Result_DO=1 and Valid_SO=1 stable throughout, Ready_SO=0; Ready_SI=1 -> IDLE the next cycle.
REQ-039 SHALL cover: Rst_RI=1 asserted in the 2nd SHIFT cycle of 1.0 -> next cycle Ready_SO=1, Valid_SO=0 and Result_DO=0, with no stale result ever presented.
